key_move_ctrl: RTL

KEY_MOVE_CTRL -- requirements
Module: key_move_ctrl

---
 rtl/maze_pkg.sv | 45 ++++
 rtl/key_move_ctrl_if.sv | 20 ++
 rtl/key_debounce.sv | 44 ++++
 rtl/key_move_ctrl.sv | 120 ++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types for the maze key-input path: key codes, move-FSM states and
// the helpers used for key arbitration and counter sizing.
package maze_pkg;

    typedef enum logic [1:0] {
        KEY_NONE  = 2'd0,
        KEY_UP    = 2'd1,
        KEY_DOWN  = 2'd2,
        KEY_RIGHT = 2'd3
    } key_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } move_state_e;

    // Bit positions in the debounced-pressed vector.
    localparam int unsigned BIT_UP    = 0;
    localparam int unsigned BIT_DOWN  = 1;
    localparam int unsigned BIT_RIGHT = 2;

    typedef logic [2:0] key_vec_t;

    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

    function automatic key_e arbitrate(input key_vec_t pressed);
        if (pressed[BIT_UP])    return KEY_UP;
        if (pressed[BIT_DOWN])  return KEY_DOWN;
        if (pressed[BIT_RIGHT]) return KEY_RIGHT;
        return KEY_NONE;
    endfunction

    function automatic logic is_pressed(input key_e key, input key_vec_t pressed);
        case (key)
            KEY_UP:    return pressed[BIT_UP];
            KEY_DOWN:  return pressed[BIT_DOWN];
            KEY_RIGHT: return pressed[BIT_RIGHT];
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/key_move_ctrl_if.sv
// Raw active-low key pads in, one-cycle move pulses and the held flag out.
interface key_move_ctrl_if;
    logic key_up_n;
    logic key_down_n;
    logic key_right_n;
    logic moveup;
    logic movedown;
    logic moveright;
    logic held;

    modport master (
        output key_up_n, key_down_n, key_right_n,
        input  moveup, movedown, moveright, held
    );

    modport slave (
        input  key_up_n, key_down_n, key_right_n,
        output moveup, movedown, moveright, held
    );
endinterface

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer followed by a saturating debounce
// counter; pressed_o flips only after DEBOUNCE_CYCLES stable differing cycles.
module key_debounce
    import maze_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic pressed_o
);
    localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d;   // debounced, active-low like the pad
    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], key_n_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: defaults first, so no path through the block leaves a latch behind.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_LAST) level_d = sync_q[1];
            else                   cnt_d   = cnt_q + CW'(1);
        end
    end

    assign pressed_o = ~level_q;
endmodule

// File: rtl/key_move_ctrl.sv
// Maze move controller: debounces three push-buttons, latches one key by
// priority and emits registered move pulses with optional auto-repeat.
module key_move_ctrl
    import maze_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input logic            clk,
    input logic            rst,
    key_move_ctrl_if.slave bus
);
    localparam int unsigned   TIMER_SPAN  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                          : REPEAT_PERIOD;
    localparam int unsigned   TW          = cnt_width(TIMER_SPAN);
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    key_vec_t      deb_pressed;
    key_vec_t      pressed_q;
    key_e          sel_key;
    logic          still_held;
    move_state_e   state_q, state_d;
    key_e          latched_q, latched_d;
    key_e          pulse_q, pulse_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          moveup_q, movedown_q, moveright_q, held_q;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clk(clk), .rst(rst), .key_n_i(bus.key_up_n), .pressed_o(deb_pressed[BIT_UP])
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
        .clk(clk), .rst(rst), .key_n_i(bus.key_down_n), .pressed_o(deb_pressed[BIT_DOWN])
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .clk(clk), .rst(rst), .key_n_i(bus.key_right_n), .pressed_o(deb_pressed[BIT_RIGHT])
    );

    assign sel_key    = arbitrate(pressed_q);
    assign still_held = is_pressed(latched_q, pressed_q);

    // pressed_q, pulse_q and the output flops fix first-pulse latency at DEBOUNCE_CYCLES+4.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pressed_q   <= '0;
            state_q     <= IDLE;
            latched_q   <= KEY_NONE;
            pulse_q     <= KEY_NONE;
            timer_q     <= '0;
            moveup_q    <= 1'b0;
            movedown_q  <= 1'b0;
            moveright_q <= 1'b0;
            held_q      <= 1'b0;
        end else begin
            pressed_q   <= deb_pressed;
            state_q     <= state_d;
            latched_q   <= latched_d;
            pulse_q     <= pulse_d;
            timer_q     <= timer_d;
            moveup_q    <= (pulse_q == KEY_UP);
            movedown_q  <= (pulse_q == KEY_DOWN);
            moveright_q <= (pulse_q == KEY_RIGHT);
            held_q      <= (state_q != IDLE);
        end
    end

    always_comb begin
        state_d   = state_q;
        latched_d = latched_q;
        pulse_d   = KEY_NONE;
        timer_d   = timer_q;
        case (state_q)
            IDLE: begin
                if (sel_key != KEY_NONE) begin
                    latched_d = sel_key;
                    pulse_d   = sel_key;
                    timer_d   = '0;
                    state_d   = DELAY;
                end
            end
            DELAY: begin
                if (!still_held) begin
                    state_d   = IDLE;
                    latched_d = KEY_NONE;
                    timer_d   = '0;
                end else if (timer_q < DELAY_LAST) begin
                    timer_d = timer_q + TW'(1);
                end else if (REPEAT_EN) begin
                    pulse_d = latched_q;
                    timer_d = '0;
                    state_d = REPEAT;
                end
            end
            REPEAT: begin
                if (!still_held) begin
                    state_d   = IDLE;
                    latched_d = KEY_NONE;
                    timer_d   = '0;
                end else if (timer_q < PERIOD_LAST) begin
                    timer_d = timer_q + TW'(1);
                end else begin
                    pulse_d = latched_q;
                    timer_d = '0;
                end
            end
            default: begin
                state_d   = IDLE;
                latched_d = KEY_NONE;
                timer_d   = '0;
            end
        endcase
    end

    assign bus.moveup    = moveup_q;
    assign bus.movedown  = movedown_q;
    assign bus.moveright = moveright_q;
    assign bus.held      = held_q;
endmodule
